byte_bus_master: RTL and testbench

- Initiator for the byte-wide memory/peripheral bus (readmem/writemem/addressBus/data/memDataReady).
- Converts single CPU-side byte, halfword or word load/store requests into sequential 8-bit bus transfers.
- Assembles read bytes little-endian and returns one result with a done pulse.
- Sits between the CPU datapath and the memory controller. It drives the address decode regions for instruction memory (0x0000_0xxx), data memory (0x0010_0xxx), GPIO (0x0100_000x) and factorial (0x1000_000x).

---
 rtl/byte_bus_master_if.sv | 23 ++
 rtl/byte_bus_master.sv | 141 ++++++++++++++
 tb/tb_byte_bus_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/byte_bus_master_if.sv
// Byte-wide memory/peripheral bus shared by the master and its responders
// (readmem/writemem strobes, address, split data, memDataReady handshake).
interface byte_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              readmem;
  logic              writemem;
  logic [ADDR_W-1:0] addressBus;
  logic [DATA_W-1:0] dataBusOut;
  logic [DATA_W-1:0] dataBusIn;
  logic              memDataReady;

  modport master (
    output readmem, writemem, addressBus, dataBusOut,
    input  dataBusIn, memDataReady
  );

  modport slave (
    input  readmem, writemem, addressBus, dataBusOut,
    output dataBusIn, memDataReady
  );
endinterface

// File: rtl/byte_bus_master.sv
// Splits CPU byte/half/word loads and stores into sequential 8-bit bus beats
// and reassembles read data little-endian. Optional macro: BUS_TIMEOUT_EN.
module byte_bus_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              bus_err,
  byte_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       wdata_q;
  logic [31:0]       shadow;
  logic [31:0]       assembled;
  logic [1:0]        beat;
  logic [1:0]        last_beat;
  logic [1:0]        size_last;
  logic              op_write;
  logic              start;
  logic              beat_accept;
  logic              timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Write wins when both request lines are high in IDLE.
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    beat_accept  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    bus.readmem  = 1'b0;
    bus.writemem = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_write || req_read) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy         = 1'b1;
        bus.readmem  = ~op_write;
        bus.writemem = op_write;
        beat_accept  = bus.memDataReady;
        if ((beat_accept && beat == last_beat) || timeout) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    unique case (req_size)
      2'b00:   size_last = 2'd0;
      2'b01:   size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  end

  assign assembled      = shadow | (32'(bus.dataBusIn) << {beat, 3'b000});
  assign bus.addressBus = base_addr + ADDR_W'(beat);
  assign bus.dataBusOut = DATA_W'(wdata_q >> {beat, 3'b000});

  // rdata is loaded on the final accepted read beat so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr <= '0;
      wdata_q   <= '0;
      shadow    <= '0;
      rdata     <= '0;
      beat      <= '0;
      last_beat <= '0;
      op_write  <= 1'b0;
    end else if (start) begin
      base_addr <= req_addr;
      wdata_q   <= req_wdata;
      shadow    <= '0;
      beat      <= '0;
      last_beat <= size_last;
      op_write  <= req_write;
    end else if (beat_accept) begin
      beat <= (beat == last_beat) ? 2'd0 : beat + 2'd1;
      if (!op_write) begin
        shadow <= assembled;
        if (beat == last_beat) rdata <= assembled;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  assign timeout = (state == ACCESS) && !bus.memDataReady &&
                   (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = (state == DONE) && err_q;

  // Wait counter restarts on every accepted beat and outside ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != ACCESS || bus.memDataReady) wait_cnt <= '0;
      else                                     wait_cnt <= wait_cnt + 1'b1;
      if (start)        err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
  assign bus_err            = 1'b0;
`endif

endmodule

// File: tb/tb_byte_bus_master.sv
// Bench for byte_bus_master: directed table, multi-cycle corner sequences and
// randomized transactions against a byte-addressed memory model.
module tb_byte_bus_master;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, bus_err;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] model_rdata = 32'd0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall_beat;
    int          stall_len;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  byte_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  byte_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .bus_err(bus_err),
    .bus(bus)
  );

  function automatic logic [7:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h3C);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One full transaction; the responder side and expectations come from mem.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int stall_beat, input int stall_len, input bit rnd,
                               output logic [31:0] got_rdata);
    int          n, total, lat;
    int          waits[4];
    logic [31:0] exp_rd, a;
    logic        is_wr;
    is_wr = wr;
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    total = 0;
    for (int k = 0; k < 4; k++) begin
      if (rnd) waits[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      else     waits[k] = (k == stall_beat) ? stall_len : 0;
      if (k < n) total += waits[k];
    end
    exp_rd = model_rdata;
    if (!is_wr) begin
      exp_rd = 32'd0;
      for (int k = 0; k < n; k++) exp_rd |= 32'(memRead(addr + 32'(k))) << (8 * k);
    end
    @(negedge clk);
    req_read = rd; req_write = wr; req_size = size; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    lat = 1;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      for (int w = 0; w <= waits[k]; w++) begin
        checkOutput("beat_busy", 32'(busy), 32'd1);
        checkOutput("beat_done", 32'(done), 32'd0);
        checkOutput("beat_readmem", 32'(bus.readmem), 32'(!is_wr));
        checkOutput("beat_writemem", 32'(bus.writemem), 32'(is_wr));
        checkOutput("beat_address", bus.addressBus, a);
        if (is_wr) checkOutput("beat_wdata", 32'(bus.dataBusOut), 32'(wdata[8*k +: 8]));
        bus.memDataReady = (w == waits[k]);
        bus.dataBusIn    = (w == waits[k] && !is_wr) ? memRead(a) : 8'($urandom);
        if (w == waits[k] && is_wr) mem[a] = wdata[8*k +: 8];
        req_read  = 1'($urandom);
        req_write = 1'($urandom);
        @(negedge clk);
        lat++;
      end
    end
    bus.memDataReady = 1'b0;
    while (done !== 1'b1 && lat < n + total + 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(n + total + 1));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_strobes", 32'({bus.readmem, bus.writemem}), 32'd0);
    checkOutput("done_bus_err", 32'(bus_err), 32'd0);
    checkOutput("done_rdata", rdata, exp_rd);
    got_rdata   = rdata;
    model_rdata = exp_rd;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] base;
    logic        wr;

    vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0010_0004, 32'hA1B2_C3D4, -1, 0, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 2'b10, 32'h0010_0004, 32'h0,         -1, 0, 32'hA1B2_C3D4};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 32'h0100_0000, 32'h0000_005A, -1, 0, 32'hA1B2_C3D4};
    vecs[3] = '{1'b0, 1'b1, 2'b00, 32'h0100_0000, 32'h0,         -1, 0, 32'h0000_005A};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 32'h0010_0010, 32'h0000_BEEF,  1, 3, 32'h0000_005A};
    vecs[5] = '{1'b1, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'h1122_3344, -1, 0, 32'h0000_005A};
    vecs[6] = '{1'b0, 1'b1, 2'b11, 32'hFFFF_FFFE, 32'h0,         -1, 0, 32'h1122_3344};
    vecs[7] = '{1'b0, 1'b1, 2'b01, 32'h0010_0010, 32'h0,          0, 2, 32'h0000_BEEF};

    rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_addr = 32'd0; req_wdata = 32'd0;
    bus.memDataReady = 1'b0; bus.dataBusIn = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_strobes", 32'({bus.readmem, bus.writemem}), 32'd0);
    checkOutput("rst_address", bus.addressBus, 32'd0);
    checkOutput("rst_dataout", 32'(bus.dataBusOut), 32'd0);
    checkOutput("rst_busy_done", 32'({busy, done}), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    vecs[i].stall_beat, vecs[i].stall_len, 1'b0, got);
      checkOutput($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       base = 32'h0000_0000 + $urandom_range(0, 32'hFFF);
        1:       base = 32'h0010_0000 + $urandom_range(0, 32'hFFF);
        2:       base = 32'h0100_0000 + $urandom_range(0, 15);
        default: base = 32'h1000_0000 + $urandom_range(0, 15);
      endcase
      wr = 1'($urandom);
      applyStimulus(wr, (!wr) | 1'($urandom), 2'($urandom), base, $urandom,
                    -1, 0, 1'b1, got);
    end

    // Both requests high, then reset two beats into a word store.
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_addr = 32'h0010_0020; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    checkOutput("rstseq_writemem", 32'({bus.writemem, bus.readmem}), 32'b10);
    checkOutput("rstseq_addr0", bus.addressBus, 32'h0010_0020);
    bus.memDataReady = 1'b1;
    mem[32'h0010_0020] = 8'h0D;
    @(negedge clk);
    checkOutput("rstseq_addr1", bus.addressBus, 32'h0010_0021);
    bus.memDataReady = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'd0;
    checkOutput("rstseq_strobes", 32'({bus.readmem, bus.writemem}), 32'd0);
    checkOutput("rstseq_busy", 32'(busy), 32'd0);
    checkOutput("rstseq_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstseq_no_done", 32'({busy, done}), 32'd0);
    end

    // Responder never ready.
    @(negedge clk);
    req_read = 1'b1; req_size = 2'b10; req_addr = 32'h1000_0000;
    @(negedge clk);
    req_read = 1'b0;
`ifdef BUS_TIMEOUT_EN
    begin
      int lat;
      lat = 1;
      while (done !== 1'b1 && lat < TIMEOUT_CYCLES + 10) begin
        @(negedge clk);
        lat++;
      end
      checkOutput("timeout_latency", 32'(lat), 32'(TIMEOUT_CYCLES + 1));
      checkOutput("timeout_bus_err", 32'(bus_err), 32'd1);
      checkOutput("timeout_rdata", rdata, model_rdata);
      @(negedge clk);
      checkOutput("timeout_err_clear", 32'({bus_err, done}), 32'd0);
    end
`else
    for (int i = 0; i < 40; i++) begin
      checkOutput("stuck_busy", 32'(busy), 32'd1);
      checkOutput("stuck_done_err", 32'({done, bus_err}), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("stuck_recover", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
